// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between instruction fetch and data access.
// Each grant runs WAIT_CYC strobe cycles and then returns a one-cycle ack to the winning port.
module mips_mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_adr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_adr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       last_dm;
    logic       gnt_dm;
    logic       gnt_we;
    logic       pick_dm;
    logic       any_req;

    // On a tie the port that did not win last time goes first.
    assign pick_dm = dm_req && (!if_req || !last_dm);
    assign any_req = dm_req || if_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            last_dm   <= 1'b0;
            gnt_dm    <= 1'b0;
            gnt_we    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        state   <= StAccess;
                        cnt     <= 4'(WAIT_CYC - 1);
                        last_dm <= pick_dm;
                        gnt_dm  <= pick_dm;
                        if (pick_dm) begin
                            gnt_we    <= dm_we;
                            mem_adr   <= dm_adr;
                            mem_wdata <= dm_wdata;
                            mem_rd    <= !dm_we;
                            mem_wr    <= dm_we;
                        end else begin
                            gnt_we    <= 1'b0;
                            mem_adr   <= if_adr;
                            mem_wdata <= '0;
                            mem_rd    <= 1'b1;
                            mem_wr    <= 1'b0;
                        end
                    end
                end
                StAccess: begin
                    if (cnt == 4'd0) begin
                        state     <= StDone;
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                        mem_adr   <= '0;
                        mem_wdata <= '0;
                        if (!gnt_we) begin
                            if (gnt_dm) dm_rdata <= mem_rdata;
                            else        if_rdata <= mem_rdata;
                        end
                        if (gnt_dm) dm_ack <= 1'b1;
                        else        if_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(if_ack && dm_ack));
            assert (!(mem_rd && mem_wr));
        end
    end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter with WAIT_CYC=2.
module tb_mips_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_adr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_adr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; if_adr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_adr = '0; dm_wdata = '0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input bit for_dm, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (for_dm ? dm_ack : if_ack) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({if_ack, dm_ack, mem_rd, mem_wr} !== 4'b0 || if_rdata !== 32'h0 ||
            dm_rdata !== 32'h0 || mem_adr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: acks/strobes=%b if_rdata=%h dm_rdata=%h adr=%h wdata=%h required all 0",
                     {if_ack, dm_ack, mem_rd, mem_wr}, if_rdata, dm_rdata, mem_adr, mem_wdata);
        end
    endtask

    task automatic test_fetch();
        do_reset();
        if_req = 1'b1; if_adr = 32'h10; mem_rdata = 32'h8C010004;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (dm_ack !== 1'b0) begin
                errors++;
                $display("FAIL fetch_no_dm_ack: cycle %0d dm_ack=%b required 0", c, dm_ack);
            end
            checks++;
            if (c < 3 && {mem_rd, mem_wr, if_ack} !== 3'b100) begin
                errors++;
                $display("FAIL fetch_strobe: cycle %0d rd/wr/ack=%b required 100", c,
                         {mem_rd, mem_wr, if_ack});
            end else if (c < 3 && mem_adr !== 32'h10) begin
                errors++;
                $display("FAIL fetch_adr: cycle %0d mem_adr=%h required 00000010", c, mem_adr);
            end else if (c == 3 && ({mem_rd, if_ack} !== 2'b01 || if_rdata !== 32'h8C010004)) begin
                errors++;
                $display("FAIL fetch_ack: rd/ack=%b if_rdata=%h required 01 8c010004",
                         {mem_rd, if_ack}, if_rdata);
            end
        end
        if_req = 1'b0;
        step();
        checks++;
        if ({if_ack, mem_rd} !== 2'b00 || if_rdata !== 32'h8C010004) begin
            errors++;
            $display("FAIL fetch_pulse: ack/rd=%b if_rdata=%h required 00 8c010004",
                     {if_ack, mem_rd}, if_rdata);
        end
    endtask

    task automatic test_dm_write();
        int n;
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_adr = 32'h44; mem_rdata = 32'h12345678;
        wait_ack(1'b1, 10, n);
        dm_req = 1'b0;
        checks++;
        if (n != 3 || dm_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL dm_read: latency %0d rdata=%h required 3 12345678", n, dm_rdata);
        end
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_adr = 32'h200; dm_wdata = 32'hDEADBEEF;
        mem_rdata = 32'hFFFFFFFF;
        for (int c = 1; c <= 2; c++) begin
            step();
            checks++;
            if ({mem_wr, mem_rd, dm_ack} !== 3'b100 || mem_adr !== 32'h200 ||
                mem_wdata !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL dm_write_strobe: cycle %0d wr/rd/ack=%b adr=%h wdata=%h required 100 200 deadbeef",
                         c, {mem_wr, mem_rd, dm_ack}, mem_adr, mem_wdata);
            end
        end
        step();
        dm_req = 1'b0;
        checks++;
        if ({mem_wr, mem_rd, dm_ack, if_ack} !== 4'b0010 || dm_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL dm_write_ack: wr/rd/dack/iack=%b dm_rdata=%h required 0010 12345678",
                     {mem_wr, mem_rd, dm_ack, if_ack}, dm_rdata);
        end
        step();
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        if_req = 1'b1; if_adr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_adr = 32'h60;
        wait_ack(1'b1, 10, n);
        checks++;
        if (n != 3 || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL tie_data_first: dm_ack latency %0d if_ack=%b required 3 0", n, if_ack);
        end
        dm_req = 1'b0;
        wait_ack(1'b0, 10, n);
        if_req = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL tie_fetch_second: if_ack after %0d cycles required 4", n);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int nacks = 0;
        int both = 0;
        bit exp_dm = 1'b1;
        do_reset();
        if_req = 1'b1; if_adr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_adr = 32'h60;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (if_ack && dm_ack) both++;
            if (if_ack || dm_ack) begin
                checks++;
                if (dm_ack !== exp_dm || (last >= 0 ? (c - last != 4) : (c != 3))) begin
                    errors++;
                    $display("FAIL rr_order: cycle %0d dm_ack=%b prev=%0d required dm_ack=%b spacing 4",
                             c, dm_ack, last, exp_dm);
                end
                last = c;
                exp_dm = !exp_dm;
                nacks++;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        checks++;
        if (both != 0 || nacks != 10) begin
            errors++;
            $display("FAIL rr_count: coincident=%0d acks=%0d required 0 10", both, nacks);
        end
        step(); step(); step(); step();
    endtask

    task automatic test_reset_abort();
        int n;
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_adr = 32'h44; mem_rdata = 32'h5A5A5A5A;
        wait_ack(1'b1, 10, n);
        dm_req = 1'b0;
        step();
        mem_rdata = 32'hAAAA5555; dm_req = 1'b1;
        step();
        step();
        checks++;
        if (mem_rd !== 1'b1 || dm_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL abort_setup: mem_rd=%b dm_rdata=%h required 1 5a5a5a5a", mem_rd, dm_rdata);
        end
        rst = 1'b1; dm_req = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if ({mem_rd, mem_wr, dm_ack, if_ack} !== 4'b0 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset: rd/wr/dack/iack=%b dm_rdata=%h required 0000 0",
                     {mem_rd, mem_wr, dm_ack, if_ack}, dm_rdata);
        end
        step();
        checks++;
        if ({mem_rd, dm_ack, if_ack} !== 3'b0) begin
            errors++;
            $display("FAIL abort_no_ack: rd/dack/iack=%b required 000", {mem_rd, dm_ack, if_ack});
        end
        if_req = 1'b1; if_adr = 32'h80; mem_rdata = 32'h01234567;
        wait_ack(1'b0, 10, n);
        if_req = 1'b0;
        checks++;
        if (n != 3 || if_rdata !== 32'h01234567) begin
            errors++;
            $display("FAIL abort_recover: latency %0d if_rdata=%h required 3 01234567", n, if_rdata);
        end
        step();
    endtask

    task automatic test_latch_inputs();
        do_reset();
        if_req = 1'b1; if_adr = 32'h300; mem_rdata = 32'h11112222;
        step();
        dm_req = 1'b1; dm_we = 1'b0; dm_adr = 32'h400; if_adr = 32'h999; if_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (mem_adr !== 32'h300 || mem_rd !== 1'b1) begin
                errors++;
                $display("FAIL latch_adr: cycle %0d mem_adr=%h rd=%b required 300 1", c, mem_adr, mem_rd);
            end
            step();
        end
        checks++;
        if (if_ack !== 1'b1 || dm_ack !== 1'b0 || if_rdata !== 32'h11112222) begin
            errors++;
            $display("FAIL latch_ack: iack=%b dack=%b if_rdata=%h required 1 0 11112222",
                     if_ack, dm_ack, if_rdata);
        end
        step();
        mem_rdata = 32'h33334444;
        step();
        checks++;
        if (mem_rd !== 1'b1 || mem_adr !== 32'h400) begin
            errors++;
            $display("FAIL pending_grant: rd=%b mem_adr=%h required 1 400", mem_rd, mem_adr);
        end
        step(); step();
        dm_req = 1'b0;
        checks++;
        if (dm_ack !== 1'b1 || dm_rdata !== 32'h33334444 || if_rdata !== 32'h11112222) begin
            errors++;
            $display("FAIL pending_ack: dack=%b dm_rdata=%h if_rdata=%h required 1 33334444 11112222",
                     dm_ack, dm_rdata, if_rdata);
        end
        step();
    endtask

    initial begin
        step();
        test_reset();
        test_fetch();
        test_dm_write();
        test_tie();
        test_back_to_back();
        test_reset_abort();
        test_latch_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
